// File: rtl/rx_bit_sampler_pkg.sv
// Shared RX constants: one-hot frame states, vote/acquire/bit-end counter points.
// The byte-analyse stage imports the same package so both sides agree on timing.
package rx_bit_sampler_pkg;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rx_state_t;

    localparam logic [3:0] VOTE_A       = 4'd5;
    localparam logic [3:0] VOTE_B       = 4'd6;
    localparam logic [3:0] ACQ_POINT    = 4'd7;
    localparam logic [3:0] BIT_END      = 4'd15;
    localparam logic [3:0] RX_STOP_EXIT = 4'd11;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_line_filter.sv
// Serial line conditioning: 2-FF synchroniser, falling-edge detect and
// 3-sample majority vote (samples at counts 5 and 6 plus the live value at 7).
module rx_line_filter
    import rx_bit_sampler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    input  logic       tick,
    input  logic [3:0] cnt,
    output logic       fall,
    output logic       bit_val
);

    logic sync_q1;
    logic sync_q2;
    logic rx_prev;
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            rx_prev <= 1'b1;
            samp_a  <= 1'b1;
            samp_b  <= 1'b1;
        end else begin
            sync_q1 <= rx_i;
            sync_q2 <= sync_q1;
            rx_prev <= sync_q2;
            if (tick && cnt == VOTE_A) samp_a <= sync_q2;
            if (tick && cnt == VOTE_B) samp_b <= sync_q2;
        end
    end

    assign fall    = rx_prev & ~sync_q2;
    assign bit_val = majority3(samp_a, samp_b, sync_q2);

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX front end: frame FSM, 16x bit-width counter and 12-bit sample shift register.
//   state     | meaning
//   ST_IDLE   | waiting for a high->low edge on the synchronised line
//   ST_START  | start bit; a voted 1 is a false start
//   ST_DATA   | eight data bits, LSB first
//   ST_PARITY | optional parity bit, shifted together with the expected value
//   ST_STOP   | stop bit; a voted 0 flags a frame error
module rx_bit_sampler
    import rx_bit_sampler_pkg::*;
#(
    parameter int         OVERSAMPLE = 16,
    parameter logic [3:0] STOP_EXIT  = RX_STOP_EXIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic        p_BaudTick_i,
    input  logic        p_ParityEnable_i,
    input  logic        p_OddParity_i,
    output logic [4:0]  State_o,
    output logic [3:0]  BitWidthCnt_o,
    output logic [11:0] byte_o,
    output logic        Bit_Synch_o,
    output logic        p_FrameError_o
);

    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [3:0]  cnt;
    logic [2:0]  bit_idx;
    logic        par_acc;
    logic [11:0] shreg;
    logic        synch;
    logic        ferr;
    logic        fall;
    logic        bit_val;
    logic        acq_tick;
    logic        end_tick;

    rx_line_filter u_filter (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx_i),
        .tick    (p_BaudTick_i),
        .cnt     (cnt),
        .fall    (fall),
        .bit_val (bit_val)
    );

    assign acq_tick = p_BaudTick_i && (cnt == ACQ_POINT);
    assign end_tick = p_BaudTick_i && (cnt == BIT_END);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fall) state_nxt = ST_START;
            ST_START: begin
                if (acq_tick && bit_val) state_nxt = ST_IDLE;
                else if (end_tick)       state_nxt = ST_DATA;
            end
            ST_DATA:   if (end_tick && bit_idx == 3'd7)
                           state_nxt = p_ParityEnable_i ? ST_PARITY : ST_STOP;
            ST_PARITY: if (end_tick) state_nxt = ST_STOP;
            ST_STOP:   if (p_BaudTick_i && cnt == STOP_EXIT) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            par_acc <= 1'b0;
            shreg   <= '0;
            synch   <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            synch <= 1'b0;
            ferr  <= 1'b0;

            // A tick landing on a state change clears rather than counts.
            if (state_nxt != state)
                cnt <= '0;
            else if (p_BaudTick_i && state != ST_IDLE)
                cnt <= (cnt == CNT_LAST) ? 4'd0 : cnt + 4'd1;

            if (state == ST_IDLE && state_nxt == ST_START) begin
                shreg   <= '0;
                bit_idx <= '0;
                par_acc <= 1'b0;
            end else if (acq_tick && state != ST_IDLE) begin
                synch <= 1'b1;
                // Parity slot carries the expected bit too, so downstream XORs [1:0].
                if (state == ST_PARITY)
                    shreg <= {shreg[9:0], par_acc ^ p_OddParity_i, bit_val};
                else
                    shreg <= {shreg[10:0], bit_val};
                if (state == ST_DATA) par_acc <= par_acc ^ bit_val;
                if (state == ST_STOP && !bit_val) ferr <= 1'b1;
            end

            if (state == ST_DATA && end_tick) bit_idx <= bit_idx + 3'd1;
        end
    end

    assign State_o        = state;
    assign BitWidthCnt_o  = cnt;
    assign byte_o         = shreg;
    assign Bit_Synch_o    = synch;
    assign p_FrameError_o = ferr;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Scoreboard bench for rx_bit_sampler: stimulus pushes expected bit landings,
// a monitor pops and compares on every Bit_Synch_o pulse.
module tb_rx_bit_sampler;

    localparam logic [4:0] S_IDLE   = 5'b00001;
    localparam logic [4:0] S_START  = 5'b00010;
    localparam logic [4:0] S_DATA   = 5'b00100;
    localparam logic [4:0] S_PARITY = 5'b01000;
    localparam logic [4:0] S_STOP   = 5'b10000;
    localparam int CLK_PER_BIT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_i = 1'b1;
    logic        p_BaudTick_i = 1'b0;
    logic        p_ParityEnable_i = 1'b0;
    logic        p_OddParity_i = 1'b0;
    logic [4:0]  State_o;
    logic [3:0]  BitWidthCnt_o;
    logic [11:0] byte_o;
    logic        Bit_Synch_o;
    logic        p_FrameError_o;

    typedef struct packed {
        logic [4:0]  st;
        logic [11:0] by;
        logic [3:0]  cnt;
        logic        fe;
    } exp_t;

    exp_t        sb[$];
    logic [11:0] model;
    int          total = 0;
    int          bad = 0;
    int          synch_seen = 0;
    int          ferr_seen = 0;

    rx_bit_sampler dut (
        .clk              (clk),
        .rst              (rst),
        .rx_i             (rx_i),
        .p_BaudTick_i     (p_BaudTick_i),
        .p_ParityEnable_i (p_ParityEnable_i),
        .p_OddParity_i    (p_OddParity_i),
        .State_o          (State_o),
        .BitWidthCnt_o    (BitWidthCnt_o),
        .byte_o           (byte_o),
        .Bit_Synch_o      (Bit_Synch_o),
        .p_FrameError_o   (p_FrameError_o)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            p_BaudTick_i = (div == 3);
            div = (div + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [4:0] st, input logic [11:0] by, input logic [3:0] c, input logic fe);
        exp_t e;
        e.st = st; e.by = by; e.cnt = c; e.fe = fe;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[7-i] = d[i];
        return r;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (p_FrameError_o) ferr_seen++;
            if (Bit_Synch_o) begin
                synch_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bit_synch: got pulse with byte_o=%0h expected none", byte_o);
                end else begin
                    e = sb.pop_front();
                    check("bit_state", {27'd0, State_o}, {27'd0, e.st});
                    check("bit_byte", {20'd0, byte_o}, {20'd0, e.by});
                    check("bit_cnt", {28'd0, BitWidthCnt_o}, {28'd0, e.cnt});
                    check("bit_ferr", {31'd0, p_FrameError_o}, {31'd0, e.fe});
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (CLK_PER_BIT) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic odd,
                              input logic pbit, input logic stop, input string tag);
        logic p;
        logic seen;
        logic [3:0] last;
        int n0;
        int f0;
        p_ParityEnable_i = pe;
        p_OddParity_i = odd;
        n0 = synch_seen;
        f0 = ferr_seen;
        model = 12'h000;
        model = {model[10:0], 1'b0};
        push(S_START, model, 4'd8, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            model = {model[10:0], d[i]};
            push(S_DATA, model, 4'd8, 1'b0);
            drive_bit(d[i]);
        end
        check({tag, "_data_byte"}, {24'd0, byte_o[7:0]}, {24'd0, rev8(d)});
        if (pe) begin
            p = (^d) ^ odd;
            model = {model[9:0], p, pbit};
            push(S_PARITY, model, 4'd8, 1'b0);
            drive_bit(pbit);
            check({tag, "_parity_mismatch"}, {31'd0, byte_o[1] ^ byte_o[0]}, {31'd0, pbit ^ p});
        end
        model = {model[10:0], stop};
        push(S_STOP, model, 4'd8, ~stop);
        rx_i = stop;
        seen = 1'b0;
        last = 4'd0;
        for (int k = 0; k < CLK_PER_BIT; k++) begin
            @(posedge clk);
            #1;
            if (!seen && State_o == S_STOP) last = BitWidthCnt_o;
            else if (!seen && State_o == S_IDLE) begin
                seen = 1'b1;
                check({tag, "_stop_exit_cnt"}, {28'd0, last}, 32'd11);
            end
        end
        check({tag, "_idle_reached"}, {31'd0, seen}, 32'd1);
        check({tag, "_synch_pulses"}, n0 == 0 ? synch_seen : synch_seen - n0, pe ? 32'd11 : 32'd10);
        check({tag, "_ferr_pulses"}, ferr_seen - f0, {31'd0, ~stop});
    endtask

    initial begin : stim
        int f0;
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {27'd0, State_o}, {27'd0, S_IDLE});
        check("rst_cnt", {28'd0, BitWidthCnt_o}, 32'd0);
        check("rst_byte", {20'd0, byte_o}, 32'd0);
        check("rst_synch", {31'd0, Bit_Synch_o}, 32'd0);
        check("rst_ferr", {31'd0, p_FrameError_o}, 32'd0);
        rst = 1'b0;
        idle(20);

        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "f55");
        idle(40);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, "fA3_par_ok");
        idle(40);
        send_frame(8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, "fA3_par_bad");
        idle(40);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, "f07_odd");
        idle(40);

        // glitch: start entered, voted 1 at count 7, straight back to idle
        push(S_IDLE, 12'h001, 4'd0, 1'b0);
        rx_i = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        idle(100);
        check("glitch_state", {27'd0, State_o}, {27'd0, S_IDLE});
        idle(100);

        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "f00_stop_low");
        f0 = ferr_seen;
        rx_i = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        check("stuck_low_state", {27'd0, State_o}, {27'd0, S_IDLE});
        check("stuck_low_ferr", ferr_seen - f0, 32'd0);
        idle(100);

        // abort a frame during data bit 4
        d = 8'hC5;
        p_ParityEnable_i = 1'b0;
        model = 12'h000;
        push(S_START, 12'h000, 4'd8, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            model = {model[10:0], d[i]};
            push(S_DATA, model, 4'd8, 1'b0);
            drive_bit(d[i]);
        end
        rx_i = d[4];
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_state", {27'd0, State_o}, {27'd0, S_DATA});
        rst = 1'b1;
        #1;
        check("mid_rst_state", {27'd0, State_o}, {27'd0, S_IDLE});
        check("mid_rst_cnt", {28'd0, BitWidthCnt_o}, 32'd0);
        check("mid_rst_byte", {20'd0, byte_o}, 32'd0);
        check("mid_rst_synch", {31'd0, Bit_Synch_o}, 32'd0);
        check("mid_rst_ferr", {31'd0, p_FrameError_o}, 32'd0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(100);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, "f3C_after_rst");

        idle(40);
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, "f01_b2b");
        send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, "fFE_b2b");
        idle(100);

        check("final_state", {27'd0, State_o}, {27'd0, S_IDLE});
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
